maze_move_ctrl: RTL and testbench

- Sequences player movement for the maze game from debounced push-button events.
- Consumes the key block's one-cycle event strobe and 4-bit pressed vector, and arbitrates simultaneous presses into one direction.
- Buffers one pending move, checks the target cell against the synchronous wall map, then updates player position, move count and the win flag.
- Sits between the key debouncer and the display/maze-map logic.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/dir_arbiter.sv | 22 ++
 rtl/maze_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_maze_move_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared encodings and default game geometry for the maze block set.
//   dir_e   : 2-bit move direction (up/down/left/right)
//   state_e : movement controller state encoding (also exposed for debug)
//   MAZE_*  : default grid size, start cell and goal cell, shared with map ROM
//             and display logic.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_KEY = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_CHECK    = 3'd3,
    ST_WIN      = 3'd4
  } state_e;

  localparam int MAZE_GRID_W  = 8;
  localparam int MAZE_GRID_H  = 8;
  localparam int MAZE_START_X = 0;
  localparam int MAZE_START_Y = 0;
  localparam int MAZE_GOAL_X  = 7;
  localparam int MAZE_GOAL_Y  = 7;
  localparam int MAZE_CNT_W   = 10;

endpackage

// File: rtl/dir_arbiter.sv
// dir_arbiter: combinational 4-to-2 priority encoder for key vectors.
//   i_Key   : pressed keys, bit0 up, bit1 down, bit2 left, bit3 right
//   o_Dir   : lowest set bit wins (up > down > left > right)
//   o_Valid : at least one key pressed
module dir_arbiter
  import maze_pkg::*;
(
  input  logic [3:0] i_Key,
  output logic [1:0] o_Dir,
  output logic       o_Valid
);

  always_comb begin
    o_Valid = |i_Key;
    o_Dir   = DIR_UP;
    if (i_Key[0])      o_Dir = DIR_UP;
    else if (i_Key[1]) o_Dir = DIR_DOWN;
    else if (i_Key[2]) o_Dir = DIR_LEFT;
    else if (i_Key[3]) o_Dir = DIR_RIGHT;
  end

endmodule

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: turns debounced key events into validated player moves.
//   i_Clk, i_Rst (async, active-low), i_Start (start/restart level)
//   i_fKey/i_Key : one-cycle key event strobe and pressed-key vector
//   o_MapAddr/i_MapData : synchronous wall-map read (data one cycle after addr)
//   o_PosX/o_PosY/o_Moves : player position and successful-move count
//   o_fBump : one-cycle pulse on a rejected move; o_fWin : level in WIN
//   o_Busy : high in LOOKUP/CHECK; o_DbgState : current state_e encoding
// Handshake: a key event is accepted only by the strobe itself; there is no
// ready back to the key block, so an event that finds the single pending slot
// occupied (and not draining this cycle) is lost.
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int GRID_W  = MAZE_GRID_W,
  parameter int GRID_H  = MAZE_GRID_H,
  parameter int START_X = MAZE_START_X,
  parameter int START_Y = MAZE_START_Y,
  parameter int GOAL_X  = MAZE_GOAL_X,
  parameter int GOAL_Y  = MAZE_GOAL_Y,
  parameter int CNT_W   = MAZE_CNT_W,
  localparam int A_W = $clog2(GRID_W * GRID_H),
  localparam int X_W = $clog2(GRID_W),
  localparam int Y_W = $clog2(GRID_H)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_fKey,
  input  logic [3:0]       i_Key,
  output logic [A_W-1:0]   o_MapAddr,
  input  logic             i_MapData,
  output logic [X_W-1:0]   o_PosX,
  output logic [Y_W-1:0]   o_PosY,
  output logic [CNT_W-1:0] o_Moves,
  output logic             o_fBump,
  output logic             o_fWin,
  output logic             o_Busy,
  output logic [2:0]       o_DbgState
);

  localparam logic [X_W:0] ONE_X = 1;
  localparam logic [Y_W:0] ONE_Y = 1;

  state_e           state_q, state_d;
  logic             pend_v_q, pend_v_d;
  dir_e             pend_dir_q, pend_dir_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic [A_W-1:0]   map_addr_q, map_addr_d;
  logic             bump_q, bump_d;
  logic             win_q, win_d;
  logic             busy_q, busy_d;

  logic [1:0]       arb_dir;
  logic             arb_v;
  logic [X_W:0]     tx_w;
  logic [Y_W:0]     ty_w;
  logic             in_bounds;
  logic             consume;
  logic             capture;

  dir_arbiter u_arb (
    .i_Key   (i_Key),
    .o_Dir   (arb_dir),
    .o_Valid (arb_v)
  );

  // Target is computed one bit wider so that stepping off the low edge wraps
  // to a large value and fails the same upper-bound compare as the high edge.
  always_comb begin
    tx_w = {1'b0, pos_x_q};
    ty_w = {1'b0, pos_y_q};
    case (pend_dir_q)
      DIR_UP:    ty_w = {1'b0, pos_y_q} - ONE_Y;
      DIR_DOWN:  ty_w = {1'b0, pos_y_q} + ONE_Y;
      DIR_LEFT:  tx_w = {1'b0, pos_x_q} - ONE_X;
      default:   tx_w = {1'b0, pos_x_q} + ONE_X;
    endcase
    in_bounds = (tx_w < (X_W+1)'(GRID_W)) && (ty_w < (Y_W+1)'(GRID_H));
  end

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    moves_d    = moves_q;
    map_addr_d = map_addr_q;
    bump_d     = 1'b0;
    consume    = 1'b0;
    capture    = 1'b0;

    if (i_Start) begin
      // Restart from any state; discards an in-flight lookup result.
      state_d  = ST_WAIT_KEY;
      pos_x_d  = X_W'(START_X);
      pos_y_d  = Y_W'(START_Y);
      moves_d  = '0;
      pend_v_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_KEY: begin
          if (pend_v_q) begin
            consume = 1'b1;
            if (in_bounds) begin
              tgt_x_d    = tx_w[X_W-1:0];
              tgt_y_d    = ty_w[Y_W-1:0];
              map_addr_d = A_W'(int'(ty_w) * GRID_W + int'(tx_w));
              state_d    = ST_LOOKUP;
            end else begin
              bump_d = 1'b1;
            end
          end
        end
        ST_LOOKUP: state_d = ST_CHECK;
        ST_CHECK: begin
          if (i_MapData) begin
            bump_d  = 1'b1;
            state_d = ST_WAIT_KEY;
          end else begin
            pos_x_d = tgt_x_q;
            pos_y_d = tgt_y_q;
            if (moves_q != {CNT_W{1'b1}}) moves_d = moves_q + CNT_W'(1);
            if (tgt_x_q == X_W'(GOAL_X) && tgt_y_q == Y_W'(GOAL_Y))
              state_d = ST_WIN;
            else
              state_d = ST_WAIT_KEY;
          end
        end
        default: ;
      endcase

      // A new event may refill the slot in the same cycle it drains.
      capture = i_fKey && arb_v && (state_q != ST_IDLE) && (state_q != ST_WIN)
                && (!pend_v_q || consume);
      if (capture) begin
        pend_v_d   = 1'b1;
        pend_dir_d = dir_e'(arb_dir);
      end else if (consume) begin
        pend_v_d = 1'b0;
      end
    end

    win_d  = (state_d == ST_WIN);
    busy_d = (state_d == ST_LOOKUP) || (state_d == ST_CHECK);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      pend_v_q   <= 1'b0;
      pend_dir_q <= DIR_UP;
      pos_x_q    <= X_W'(START_X);
      pos_y_q    <= Y_W'(START_Y);
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      moves_q    <= '0;
      map_addr_q <= '0;
      bump_q     <= 1'b0;
      win_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      moves_q    <= moves_d;
      map_addr_q <= map_addr_d;
      bump_q     <= bump_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
    end
  end

  assign o_MapAddr  = map_addr_q;
  assign o_PosX     = pos_x_q;
  assign o_PosY     = pos_y_q;
  assign o_Moves    = moves_q;
  assign o_fBump    = bump_q;
  assign o_fWin     = win_q;
  assign o_Busy     = busy_q;
  assign o_DbgState = state_q;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl with an 8x8 synchronous wall-map model.
module tb_maze_move_ctrl;
  import maze_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       fkey;
  logic [3:0] key;
  logic [5:0] map_addr;
  logic       map_data;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic [9:0] moves;
  logic       bump;
  logic       win;
  logic       busy;
  logic [2:0] dbg_state;
  logic [63:0] walls;

  int n_chk;
  int n_pass;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wall-map ROM model: data follows the address by one clock.
  always @(posedge clk) map_data <= walls[map_addr];

  maze_move_ctrl dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_Start    (start),
    .i_fKey     (fkey),
    .i_Key      (key),
    .o_MapAddr  (map_addr),
    .i_MapData  (map_data),
    .o_PosX     (pos_x),
    .o_PosY     (pos_y),
    .o_Moves    (moves),
    .o_fBump    (bump),
    .o_fWin     (win),
    .o_Busy     (busy),
    .o_DbgState (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe one key event; returns in cycle 1 of that event.
  task automatic press(input logic [3:0] k);
    fkey = 1'b1;
    key  = k;
    tick();
    fkey = 1'b0;
    key  = 4'b0000;
  endtask

  // Full free move; returns in cycle 4 with the block back in WAIT_KEY.
  task automatic move(input logic [3:0] k);
    press(k);
    ticks(3);
  endtask

  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_posx"}, 32'(pos_x), 32'd0);
    check({tag, "_posy"}, 32'(pos_y), 32'd0);
    check({tag, "_moves"}, 32'(moves), 32'd0);
    check({tag, "_bump"}, 32'(bump), 32'd0);
    check({tag, "_win"}, 32'(win), 32'd0);
    check({tag, "_addr"}, 32'(map_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    walls  = '0;
    rst_n  = 1'b0;
    start  = 1'b0;
    fkey   = 1'b0;
    key    = 4'b0000;
    ticks(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    restart();
    check("start_state", 32'(dbg_state), 32'(ST_WAIT_KEY));

    // Right move with free map
    press(4'b1000);
    check("r_c1_busy", 32'(busy), 32'd0);
    tick();
    check("r_c2_busy", 32'(busy), 32'd1);
    check("r_c2_addr", 32'(map_addr), 32'd1);
    check("r_c2_state", 32'(dbg_state), 32'(ST_LOOKUP));
    tick();
    check("r_c3_posx", 32'(pos_x), 32'd0);
    tick();
    check("r_c4_posx", 32'(pos_x), 32'd1);
    check("r_c4_moves", 32'(moves), 32'd1);
    restart();
    check("restart_posx", 32'(pos_x), 32'd0);
    check("restart_moves", 32'(moves), 32'd0);

    // Out-of-bounds up, then left
    press(4'b0001);
    check("up_c1_bump", 32'(bump), 32'd0);
    tick();
    check("up_c2_bump", 32'(bump), 32'd1);
    check("up_c2_busy", 32'(busy), 32'd0);
    tick();
    check("up_c3_bump", 32'(bump), 32'd0);
    press(4'b0100);
    tick();
    check("left_c2_bump", 32'(bump), 32'd1);
    check("left_c2_busy", 32'(busy), 32'd0);
    tick();
    check("oob_posx", 32'(pos_x), 32'd0);
    check("oob_posy", 32'(pos_y), 32'd0);
    check("oob_moves", 32'(moves), 32'd0);

    // Wall below start
    walls[8] = 1'b1;
    press(4'b0010);
    tick();
    check("wall_addr", 32'(map_addr), 32'd8);
    check("wall_busy", 32'(busy), 32'd1);
    ticks(2);
    check("wall_bump", 32'(bump), 32'd1);
    check("wall_posy", 32'(pos_y), 32'd0);
    check("wall_moves", 32'(moves), 32'd0);
    tick();
    check("wall_bump_end", 32'(bump), 32'd0);
    walls[8] = 1'b0;

    // Left+right at (3,3): left wins
    restart();
    for (int i = 0; i < 3; i++) move(4'b1000);
    for (int i = 0; i < 3; i++) move(4'b0010);
    check("pri_at_x", 32'(pos_x), 32'd3);
    check("pri_at_y", 32'(pos_y), 32'd3);
    move(4'b1100);
    check("pri_posx", 32'(pos_x), 32'd2);
    check("pri_posy", 32'(pos_y), 32'd3);
    check("pri_moves", 32'(moves), 32'd7);

    // Three back-to-back strobes: right, down executed, third dropped
    restart();
    fkey = 1'b1; key = 4'b1000;
    tick();
    key = 4'b0010;
    tick();
    key = 4'b1000;
    tick();
    fkey = 1'b0; key = 4'b0000;
    ticks(6);
    check("b2b_posx", 32'(pos_x), 32'd1);
    check("b2b_posy", 32'(pos_y), 32'd1);
    check("b2b_moves", 32'(moves), 32'd2);
    ticks(5);
    check("b2b_moves_late", 32'(moves), 32'd2);

    // Abort during LOOKUP
    restart();
    press(4'b1000);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(ST_WAIT_KEY));
    check("abort_busy", 32'(busy), 32'd0);
    ticks(3);
    check("abort_posx", 32'(pos_x), 32'd0);
    check("abort_moves", 32'(moves), 32'd0);

    // Free path to the goal
    restart();
    for (int i = 0; i < 7; i++) move(4'b1000);
    for (int i = 0; i < 6; i++) move(4'b0010);
    check("pre_goal_win", 32'(win), 32'd0);
    move(4'b0010);
    check("goal_win", 32'(win), 32'd1);
    check("goal_posx", 32'(pos_x), 32'd7);
    check("goal_posy", 32'(pos_y), 32'd7);
    check("goal_moves", 32'(moves), 32'd14);
    check("goal_state", 32'(dbg_state), 32'(ST_WIN));
    move(4'b0100);
    check("win_ign_posx", 32'(pos_x), 32'd7);
    check("win_ign_moves", 32'(moves), 32'd14);
    check("win_ign_win", 32'(win), 32'd1);
    restart();
    check("win_rst_win", 32'(win), 32'd0);
    check("win_rst_posx", 32'(pos_x), 32'd0);
    check("win_rst_posy", 32'(pos_y), 32'd0);
    check("win_rst_moves", 32'(moves), 32'd0);

    // Async reset in CHECK
    move(4'b1000);
    press(4'b1000);
    ticks(2);
    check("chk_state", 32'(dbg_state), 32'(ST_CHECK));
    check("chk_moves", 32'(moves), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
